// File: rtl/openhw_cache_fill_seq_pkg.sv
// rtl/openhw_cache_fill_seq_pkg.sv - shared types and helpers for the cache line-fill sequencer
package openhw_cache_fill_seq_pkg;

   typedef enum logic [1:0] {
      FILL_IDLE,
      FILL_ACTIVE,
      FILL_DONE
   } fill_state_e;

   function automatic int calc_bpw(input int width, input int busw);
      return width / busw;
   endfunction

endpackage

// File: rtl/openhw_cache_fill_seq_if.sv
// rtl/openhw_cache_fill_seq_if.sv - fill request, beat stream, read lookup and RAM port bundle
interface openhw_cache_fill_seq_if #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 128,
   parameter int BUSW  = 64
);
   localparam int AW = $clog2(DEPTH);

   logic             fill_req;
   logic             fill_ready;
   logic [AW-1:0]    fill_addr;
   logic             abort;
   logic             beat_valid;
   logic             beat_ready;
   logic [BUSW-1:0]  beat_data;
   logic             fill_done;
   logic             rd_req;
   logic [AW-1:0]    rd_addr;
   logic             rd_gnt;
   logic             ram_ce;
   logic             ram_we;
   logic [AW-1:0]    ram_addr;
   logic [WIDTH-1:0] ram_din;

   modport slave (
      input  fill_req, fill_addr, abort, beat_valid, beat_data, rd_req, rd_addr,
      output fill_ready, beat_ready, fill_done, rd_gnt, ram_ce, ram_we, ram_addr, ram_din
   );

   modport master (
      output fill_req, fill_addr, abort, beat_valid, beat_data, rd_req, rd_addr,
      input  fill_ready, beat_ready, fill_done, rd_gnt, ram_ce, ram_we, ram_addr, ram_din
   );

endinterface

// File: rtl/openhw_cache_fill_seq_packer.sv
// rtl/openhw_cache_fill_seq_packer.sv - packs bus beats into RAM-width words
module openhw_fill_beat_packer
   import openhw_cache_fill_seq_pkg::*;
#(
   parameter int WIDTH = 128,
   parameter int BUSW  = 64
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             beat_fire,
   input  logic [BUSW-1:0]  beat_data,
   output logic             word_complete,
   output logic [WIDTH-1:0] word_data
);
   localparam int BPW = calc_bpw(WIDTH, BUSW);

   generate
      if (BPW == 1) begin : g_direct
         logic unused;
         assign unused        = clear ^ clk ^ reset_n;
         assign word_complete = beat_fire;
         assign word_data     = beat_data;
      end else begin : g_pack
         localparam int BCW = $clog2(BPW);
         localparam int PW  = (BPW - 1) * BUSW;

         logic [BCW-1:0] bcnt_q, bcnt_d;
         logic [PW-1:0]  pack_q, pack_d;
         logic           last_slot;

         assign last_slot = (bcnt_q == BCW'(BPW - 1));

         // The final beat bypasses the register so the word is written with no bubble.
         always_comb begin
            bcnt_d = bcnt_q;
            pack_d = pack_q;
            if (clear) begin
               bcnt_d = '0;
            end else if (beat_fire) begin
               if (last_slot) begin
                  bcnt_d = '0;
               end else begin
                  bcnt_d = bcnt_q + BCW'(1);
                  pack_d[bcnt_q*BUSW +: BUSW] = beat_data;
               end
            end
         end

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               bcnt_q <= '0;
               pack_q <= '0;
            end else begin
               bcnt_q <= bcnt_d;
               pack_q <= pack_d;
            end
         end

         assign word_complete = beat_fire & last_slot;
         assign word_data     = {beat_data, pack_q};
      end
   endgenerate

endmodule

// File: rtl/openhw_cache_fill_seq.sv
// rtl/openhw_cache_fill_seq.sv - critical-word-first line fill sequencer with RAM port arbitration
module openhw_cache_fill_seq
   import openhw_cache_fill_seq_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int WIDTH = 128,
   parameter int BUSW  = 64,
   parameter int WORDS = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   openhw_cache_fill_seq_if.slave bus
);
   localparam int            AW        = $clog2(DEPTH);
   localparam int            OW        = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [AW-1:0] LINE_MASK = AW'(WORDS - 1);

   fill_state_e    state_q, state_d;
   logic [AW-1:0]  base_q, base_d;
   logic [OW-1:0]  woff_q, woff_d;
   logic [OW-1:0]  wcnt_q, wcnt_d;

   logic             beat_fire;
   logic             pack_clear;
   logic             word_complete;
   logic [WIDTH-1:0] word_data;
   logic [AW-1:0]    wr_addr;
   logic             last_word;

   assign bus.fill_ready = (state_q == FILL_IDLE);
   assign bus.beat_ready = (state_q == FILL_ACTIVE) & ~bus.abort;
   assign bus.fill_done  = (state_q == FILL_DONE);
   assign beat_fire      = bus.beat_valid & bus.beat_ready;
   assign pack_clear     = ((state_q == FILL_IDLE) & bus.fill_req) |
                           ((state_q == FILL_ACTIVE) & bus.abort);

   openhw_fill_beat_packer #(
      .WIDTH (WIDTH),
      .BUSW  (BUSW)
   ) u_packer (
      .clk           (clk),
      .reset_n       (reset_n),
      .clear         (pack_clear),
      .beat_fire     (beat_fire),
      .beat_data     (bus.beat_data),
      .word_complete (word_complete),
      .word_data     (word_data)
   );

   // Offset arithmetic wraps inside the line, giving critical-word-first order.
   assign wr_addr   = base_q | (AW'(woff_q + wcnt_q) & LINE_MASK);
   assign last_word = (wcnt_q == OW'(WORDS - 1));

   assign bus.ram_we   = word_complete;
   assign bus.rd_gnt   = bus.rd_req & ~bus.ram_we;
   assign bus.ram_ce   = bus.ram_we | bus.rd_gnt;
   assign bus.ram_addr = bus.ram_we ? wr_addr : bus.rd_addr;
   assign bus.ram_din  = word_data;

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      woff_d  = woff_q;
      wcnt_d  = wcnt_q;
      unique case (state_q)
         FILL_IDLE: begin
            if (bus.fill_req) begin
               state_d = FILL_ACTIVE;
               base_d  = bus.fill_addr & ~LINE_MASK;
               woff_d  = OW'(bus.fill_addr & LINE_MASK);
               wcnt_d  = '0;
            end
         end
         FILL_ACTIVE: begin
            if (bus.abort) begin
               state_d = FILL_IDLE;
               wcnt_d  = '0;
               woff_d  = '0;
            end else if (word_complete) begin
               wcnt_d = wcnt_q + OW'(1);
               if (last_word) begin
                  state_d = FILL_DONE;
                  wcnt_d  = '0;
               end
            end
         end
         FILL_DONE: begin
            state_d = FILL_IDLE;
         end
         default: begin
            state_d = FILL_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= FILL_IDLE;
         base_q  <= '0;
         woff_q  <= '0;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         woff_q  <= woff_d;
         wcnt_q  <= wcnt_d;
      end
   end

endmodule

// File: tb/tb_openhw_cache_fill_seq.sv
// tb/tb_openhw_cache_fill_seq.sv - directed checks of the line-fill sequencer (BPW=2 and BPW=1)
module tb_openhw_cache_fill_seq;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   openhw_cache_fill_seq_if #(.DEPTH(64), .WIDTH(128), .BUSW(64))  ifa ();
   openhw_cache_fill_seq_if #(.DEPTH(64), .WIDTH(128), .BUSW(128)) ifb ();

   openhw_cache_fill_seq #(.DEPTH(64), .WIDTH(128), .BUSW(64), .WORDS(4)) dut_a (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (ifa)
   );

   openhw_cache_fill_seq #(.DEPTH(64), .WIDTH(128), .BUSW(128), .WORDS(4)) dut_b (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (ifb)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // exp_addrs holds word k's address in bits [6k+5:6k]; beat b carries data b.
   task automatic fill_a(input logic [5:0] addr, input bit gap, input logic [23:0] exp_addrs);
      @(negedge clk);
      ifa.fill_req  = 1'b1;
      ifa.fill_addr = addr;
      #1 check("fill_ready_idle", ifa.fill_ready, 1);
      @(negedge clk);
      ifa.fill_req = 1'b0;
      for (int b = 1; b <= 8; b++) begin
         if (gap && b > 1) begin
            ifa.beat_valid = 1'b0;
            #1 check("gap_no_write", ifa.ram_we, 0);
            @(negedge clk);
         end
         ifa.beat_valid = 1'b1;
         ifa.beat_data  = 64'(b);
         #1 check("beat_ready", ifa.beat_ready, 1);
         if (b % 2 == 0) begin
            check("ram_we", ifa.ram_we, 1);
            check("ram_ce_wr", ifa.ram_ce, 1);
            check("wr_addr", ifa.ram_addr, exp_addrs[(b/2-1)*6 +: 6]);
            check("wr_data", ifa.ram_din, {64'(b), 64'(b - 1)});
            check("rd_blocked", ifa.rd_gnt, 0);
         end else begin
            check("no_write", ifa.ram_we, 0);
            check("rd_gnt", ifa.rd_gnt, 1);
            check("rd_addr", ifa.ram_addr, 9);
         end
         @(negedge clk);
      end
      ifa.beat_valid = 1'b0;
      #1 check("fill_done", ifa.fill_done, 1);
      check("done_not_ready", ifa.fill_ready, 0);
      check("done_rd_gnt", ifa.rd_gnt, 1);
      @(negedge clk);
      #1 check("done_one_cycle", ifa.fill_done, 0);
      check("back_idle", ifa.fill_ready, 1);
   endtask

   initial begin
      ifa.fill_req = 0; ifa.fill_addr = '0; ifa.abort = 0; ifa.beat_valid = 0;
      ifa.beat_data = '0; ifa.rd_req = 1; ifa.rd_addr = 6'd9;
      ifb.fill_req = 0; ifb.fill_addr = '0; ifb.abort = 0; ifb.beat_valid = 0;
      ifb.beat_data = '0; ifb.rd_req = 0; ifb.rd_addr = '0;

      #1;
      check("rst_fill_ready", ifa.fill_ready, 1);
      check("rst_beat_ready", ifa.beat_ready, 0);
      check("rst_ram_we", ifa.ram_we, 0);
      check("rst_fill_done", ifa.fill_done, 0);
      @(negedge clk);
      reset_n = 1'b1;

      fill_a(6'd6, 1'b0, {6'd5, 6'd4, 6'd7, 6'd6});
      fill_a(6'd6, 1'b1, {6'd5, 6'd4, 6'd7, 6'd6});

      // Abort on the third beat after one word has been written.
      @(negedge clk);
      ifa.fill_req = 1'b1; ifa.fill_addr = 6'd6;
      @(negedge clk);
      ifa.fill_req = 1'b0;
      for (int b = 1; b <= 3; b++) begin
         ifa.beat_valid = 1'b1;
         ifa.beat_data  = 64'(b);
         ifa.abort      = (b == 3);
         #1;
         if (b == 2) begin
            check("abort_pre_we", ifa.ram_we, 1);
            check("abort_pre_addr", ifa.ram_addr, 6);
         end
         if (b == 3) begin
            check("abort_beat_ready", ifa.beat_ready, 0);
            check("abort_no_we", ifa.ram_we, 0);
         end
         @(negedge clk);
      end
      ifa.abort = 1'b0; ifa.beat_valid = 1'b0;
      #1 check("abort_idle", ifa.fill_ready, 1);
      check("abort_no_done", ifa.fill_done, 0);

      // New fill accepted, then reset asynchronously mid-fill.
      @(negedge clk);
      ifa.fill_req = 1'b1; ifa.fill_addr = 6'd0;
      @(negedge clk);
      ifa.fill_req = 1'b0;
      #1 check("refill_accepted", ifa.fill_ready, 0);
      check("refill_beat_ready", ifa.beat_ready, 1);
      for (int b = 1; b <= 3; b++) begin
         ifa.beat_valid = 1'b1;
         ifa.beat_data  = 64'(b);
         @(negedge clk);
      end
      ifa.beat_data = 64'd4;
      #1 check("pre_reset_we", ifa.ram_we, 1);
      #2 reset_n = 1'b0;
      #1 check("async_rst_ready", ifa.fill_ready, 1);
      check("async_rst_we", ifa.ram_we, 0);
      check("async_rst_beat_ready", ifa.beat_ready, 0);
      @(negedge clk);
      ifa.beat_valid = 1'b0;
      reset_n = 1'b1;
      fill_a(6'd0, 1'b0, {6'd3, 6'd2, 6'd1, 6'd0});

      // One beat per word: every accepted beat writes, wrapping from 3.
      @(negedge clk);
      ifb.fill_req = 1'b1; ifb.fill_addr = 6'd3;
      @(negedge clk);
      ifb.fill_req = 1'b0;
      for (int w = 0; w < 4; w++) begin
         logic [23:0] exp_b;
         exp_b = {6'd2, 6'd1, 6'd0, 6'd3};
         ifb.beat_valid = 1'b1;
         ifb.beat_data  = {64'hC0DE, 64'(w + 16)};
         #1 check("b_we", ifb.ram_we, 1);
         check("b_addr", ifb.ram_addr, exp_b[w*6 +: 6]);
         check("b_data", ifb.ram_din, {64'hC0DE, 64'(w + 16)});
         @(negedge clk);
      end
      ifb.beat_valid = 1'b0;
      #1 check("b_fill_done", ifb.fill_done, 1);
      check("b_no_we", ifb.ram_we, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
